// File: rtl/serial_sub64_if.sv
// Operand/result bundle for serial_sub64.
// The zero flag exists only when SERIAL_SUB64_ZERO_EN is defined.
interface serial_sub64_if;
  localparam int unsigned W = 64;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   diff;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB64_ZERO_EN
  logic         zero;

  modport master (output start, a, b, input diff, busy, done, zero);
  modport slave  (input start, a, b, output diff, busy, done, zero);
`else
  modport master (output start, a, b, input diff, busy, done);
  modport slave  (input start, a, b, output diff, busy, done);
`endif
endinterface

// File: rtl/serial_sub64.sv
// 64-bit unsigned subtractor computing one 16-bit chunk per clock, low chunk first.
// Define SERIAL_SUB64_ZERO_EN to add a registered zero-result flag.
module serial_sub64 (
  input  logic           clk,
  input  logic           rst,
  serial_sub64_if.slave  bus
);
  localparam int unsigned W    = 64;
  localparam int unsigned CW   = 16;
  localparam int unsigned CWX  = CW + 1;
  localparam int unsigned NCH  = W / CW;
  localparam int unsigned CNTW = 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic            load, step, last;
  logic [W-1:0]    a_q, b_q, res_q;
  logic            borrow_q;
  logic [CNTW-1:0] cnt_q;
  logic [W:0]      diff_q;
  logic            busy_q, done_q;
  logic [CW:0]     chunk_c;

  // Operands shift right each step, so the active chunk is always the low 16 bits.
  assign chunk_c = {1'b0, a_q[CW-1:0]} - {1'b0, b_q[CW-1:0]} - CWX'(borrow_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == CNTW'(NCH - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, chunk sequencing, and result publication on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      if (load) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        res_q    <= '0;
        borrow_q <= 1'b0;
        cnt_q    <= '0;
      end else if (step) begin
        a_q      <= a_q >> CW;
        b_q      <= b_q >> CW;
        res_q    <= {chunk_c[CW-1:0], res_q[W-1:CW]};
        borrow_q <= chunk_c[CW];
        cnt_q    <= cnt_q + CNTW'(1);
      end
      if (last) diff_q <= {chunk_c[CW], chunk_c[CW-1:0], res_q[W-1:CW]};
    end
  end

`ifdef SERIAL_SUB64_ZERO_EN
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       zero_q <= 1'b1;
    else if (last) zero_q <= ({chunk_c[CW-1:0], res_q[W-1:CW]} == '0);
  end

  assign bus.zero = zero_q;
`endif

  assign bus.diff = diff_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_serial_sub64.sv
// Self-checking bench for serial_sub64: directed table, corner sequences, random vs model.
module tb_serial_sub64;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub64_if bus ();
  serial_sub64 dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Wait for done (sampled 1 time unit after each edge) and check the done cycle.
  task automatic wait_done(output logic [64:0] got, output int lat);
    lat = 0;
    got = '0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
    check("latency", 65'(lat), 65'd4);
    check("busy_in_done", 65'(bus.busy), 65'd1);
    got = bus.diff;
`ifdef SERIAL_SUB64_ZERO_EN
    check("zero_flag", 65'(bus.zero), 65'(bus.diff[63:0] == 64'd0));
`endif
    @(posedge clk);
    #1;
    check("done_one_cycle", 65'(bus.done), 65'd0);
    check("idle_not_busy", 65'(bus.busy), 65'd0);
  endtask

  // Start one operation, then scramble the operand inputs to prove capture.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output logic [64:0] got);
    int lat;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    wait_done(got, lat);
  endtask

  initial begin
    logic [64:0] got;
    logic [63:0] ra, rb;
    int pulses, first_e, second_e, lat;

    vecs[0] = '{64'd1440, 64'd1256, 65'd184};
    vecs[1] = '{64'd7, 64'd14, {1'b1, 64'hFFFF_FFFF_FFFF_FFF9}};
    vecs[2] = '{64'h0000_0000_0001_0000, 64'd1, 65'h0_0000_0000_0000_FFFF};
    vecs[3] = '{64'd0, 64'd1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}};
    vecs[4] = '{64'd8446744073709551614, 64'd8446744073709551614, 65'd0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                {1'b1, 64'h8000_0000_0000_0001}};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    #1;
    check("reset_diff", bus.diff, 65'd0);
    check("reset_busy", 65'(bus.busy), 65'd0);
    check("reset_done", 65'(bus.done), 65'd0);
`ifdef SERIAL_SUB64_ZERO_EN
    check("reset_zero", 65'(bus.zero), 65'd1);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, got);
      check($sformatf("vec%0d_diff", i), got, vecs[i].exp);
    end

    // diff holds its value while idle
    repeat (3) @(posedge clk);
    #1;
    check("diff_hold", bus.diff, vecs[6].exp);

    // Second start arrives while busy and must be dropped
    pulses = 0;
    got = '0;
    @(negedge clk);
    bus.a = 64'd156722120;
    bus.b = 64'd125556;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        pulses++;
        got = bus.diff;
      end
      if (i == 1) begin
        bus.a = 64'd1;
        bus.b = 64'd1;
        bus.start = 1'b1;
      end
      if (i == 2) bus.start = 1'b0;
    end
    check("busy_start_pulses", 65'(pulses), 65'd1);
    check("busy_start_diff", got, 65'd156596564);

    // start held high: accepted at edge 0, ignored leaving DONE, next accepted at edge 6
    first_e = -1;
    second_e = -1;
    @(negedge clk);
    bus.a = 64'd100;
    bus.b = 64'd30;
    bus.start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (first_e < 0) first_e = e;
        else if (second_e < 0) second_e = e;
      end
    end
    bus.start = 1'b0;
    check("held_start_first_done", 65'(first_e), 65'd4);
    check("held_start_second_done", 65'(second_e), 65'd10);
    repeat (8) @(posedge clk);

    // Reset in the second CALC cycle aborts the operation
    pulses = 0;
    @(negedge clk);
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b = 64'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_diff", bus.diff, 65'd0);
    check("abort_busy", 65'(bus.busy), 65'd0);
    check("abort_done", 65'(bus.done), 65'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check("abort_no_done", 65'(pulses), 65'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(got, lat);
    check("post_reset_diff", got, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (i % 4)
        1: rb = ra;
        2: rb = ra + 64'($urandom_range(0, 3));
        3: rb = {ra[63:16], 16'($urandom)};
        default: ;
      endcase
      run_op(ra, rb, got);
      check($sformatf("rand%0d_diff", i), got, model(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
